// File: rtl/jk_pkg.sv
// Shared types for the JK excitation driver: J/K codes and the driver FSM states.
package jk_pkg;

    // {J,K} pair as applied to a JK flop.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_code_t;

    // One transaction walks IDLE -> DRIVE -> CHECK -> RESP -> IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10,
        RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/jk_excite.sv
// One bit of the JK excitation table: given the current Q and the wanted next
// Q, pick the J/K pair. The don't-care input decides whether the free input is
// filled with 0 (hold/set/reset only) or 1 (prefer toggle).
import jk_pkg::*;

module jk_excite (
    input  logic q,
    input  logic t,
    input  logic dc,
    output logic j,
    output logic k
);

    jk_code_t code;

    // Map the (Q, target) transition to a JK code, resolving the don't-care by dc.
    always_comb begin
        code = JK_HOLD;
        unique case ({q, t})
            2'b00:   code = dc ? JK_RESET  : JK_HOLD;   // J=0 K=X
            2'b01:   code = dc ? JK_TOGGLE : JK_SET;    // J=1 K=X
            2'b10:   code = dc ? JK_TOGGLE : JK_RESET;  // J=X K=1
            default: code = dc ? JK_SET    : JK_HOLD;   // J=X K=0
        endcase
    end

    assign {j, k} = code;

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external bank of JK flops to a requested next state for exactly
// one clock, then checks Q and Q_bar and reports pass/fail with a bitwise
// mismatch vector. Failed responses are counted in a saturating counter.
import jk_pkg::*;

module jk_excitation_driver #(
    parameter int WIDTH     = 4,
    parameter int DC_POLICY = 0,
    parameter int ERRW      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] qbar_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_ok,
    output logic [WIDTH-1:0] rsp_mismatch,
    output logic [ERRW-1:0]  err_cnt
);

    localparam logic DC_BIT = (DC_POLICY != 0);

    state_t           state;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic [WIDTH-1:0] mismatch;
    logic             accept;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        if (&v)
            return v;
        return v + {{(ERRW-1){1'b0}}, 1'b1};
    endfunction

    // Excitation is computed from the live Q so it reflects the bank at accept time.
    for (genvar b = 0; b < WIDTH; b++) begin : g_excite
        jk_excite u_excite (
            .q  (q_in[b]),
            .t  (req_target[b]),
            .dc (DC_BIT),
            .j  (exc_j[b]),
            .k  (exc_k[b])
        );
    end

    assign accept = (state == IDLE) && req_valid;

    // A bit is bad if Q missed the target or Q_bar is not the complement of Q.
    assign mismatch = (q_in ^ target_q) | (qbar_in ~^ q_in);

    // Target is plain data: captured on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept)
            target_q <= req_target;
    end

    // Transaction FSM with registered handshake, J/K and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            j_out        <= '0;
            k_out        <= '0;
            rsp_valid    <= 1'b0;
            rsp_ok       <= 1'b0;
            rsp_mismatch <= '0;
            err_cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        j_out     <= exc_j;
                        k_out     <= exc_k;
                        req_ready <= 1'b0;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    // The bank captures J/K on this edge; return it to hold.
                    j_out <= '0;
                    k_out <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    rsp_mismatch <= mismatch;
                    rsp_ok       <= ~|mismatch;
                    if (|mismatch)
                        err_cnt <= sat_inc(err_cnt);
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two drivers (DC_POLICY 0 and 1) run in
// lockstep on the same requests, each with its own modelled 4-bit JK bank.
// A stuck-at-0 mask can be applied to both banks to force failures.
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_target;
    logic       rsp_ready;
    logic [3:0] stuck;

    logic       rr0, rr1, rv0, rv1, ok0, ok1;
    logic [3:0] j0, k0, j1, k1, q0, q1, qb0, qb1, mis0, mis1;
    logic [3:0] bq0, bq1;
    logic [7:0] err0, err1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jk_excitation_driver #(.WIDTH(4), .DC_POLICY(0), .ERRW(8)) u_dc0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr0),
        .req_target(req_target), .j_out(j0), .k_out(k0), .q_in(q0), .qbar_in(qb0),
        .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_ok(ok0),
        .rsp_mismatch(mis0), .err_cnt(err0)
    );

    jk_excitation_driver #(.WIDTH(4), .DC_POLICY(1), .ERRW(8)) u_dc1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr1),
        .req_target(req_target), .j_out(j1), .k_out(k1), .q_in(q1), .qbar_in(qb1),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_ok(ok1),
        .rsp_mismatch(mis1), .err_cnt(err1)
    );

    // Behaviour of a JK flop bank: 00 hold, 01 reset, 10 set, 11 toggle.
    function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j,
                                           input logic [3:0] k);
        logic [3:0] n;
        for (int b = 0; b < 4; b++) begin
            case ({j[b], k[b]})
                2'b00:   n[b] = q[b];
                2'b01:   n[b] = 1'b0;
                2'b10:   n[b] = 1'b1;
                default: n[b] = ~q[b];
            endcase
        end
        return n;
    endfunction

    // Flop banks; stuck bits read and store as 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            bq0 <= 4'b0000;
            bq1 <= 4'b0000;
        end else begin
            bq0 <= jk_next(bq0, j0, k0) & ~stuck;
            bq1 <= jk_next(bq1, j1, k1) & ~stuck;
        end
    end

    assign q0  = bq0 & ~stuck;
    assign q1  = bq1 & ~stuck;
    assign qb0 = ~q0;
    assign qb1 = ~q1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full transaction; starts and ends at a negedge with the DUTs in IDLE.
    task automatic run_txn(input logic [3:0] tgt, input logic [3:0] j0e, input logic [3:0] k0e,
                           input logic [3:0] j1e, input logic [3:0] k1e, input logic oke,
                           input logic [3:0] mise, input logic [7:0] erre, input int hold);
        chk("req_ready_idle", {30'd0, rr1, rr0}, 32'h3);
        req_valid  = 1'b1;
        req_target = tgt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);   // DRIVE
        chk("drive_jk_dc0", {24'd0, j0, k0}, {24'd0, j0e, k0e});
        chk("drive_jk_dc1", {24'd0, j1, k1}, {24'd0, j1e, k1e});
        chk("drive_ready_valid", {28'd0, rr1, rr0, rv1, rv0}, 32'h0);
        @(negedge clk);   // CHECK
        chk("check_jk_hold", {16'd0, j0, k0, j1, k1}, 32'h0);
        chk("check_rsp_valid", {30'd0, rv1, rv0}, 32'h0);
        @(negedge clk);   // RESP
        chk("resp_valid", {30'd0, rv1, rv0}, 32'h3);
        chk("resp_ok", {30'd0, ok1, ok0}, {30'd0, oke, oke});
        chk("resp_mismatch", {24'd0, mis1, mis0}, {24'd0, mise, mise});
        chk("resp_err_cnt", {16'd0, err1, err0}, {16'd0, erre, erre});
        for (int c = 0; c < hold; c++) begin
            req_valid = 1'b1;   // must be ignored outside IDLE
            @(negedge clk);
            chk("bp_valid", {30'd0, rv1, rv0}, 32'h3);
            chk("bp_fields", {14'd0, ok1, ok0, mis1, mis0, err0},
                {14'd0, oke, oke, mise, mise, erre});
            chk("bp_ready_jk", {14'd0, rr1, rr0, j0, k0, j1, k1}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("after_resp_valid", {30'd0, rv1, rv0}, 32'h0);
        chk("after_resp_ready", {30'd0, rr1, rr0}, 32'h3);
    endtask

    typedef struct {
        logic [3:0] tgt;
        logic [3:0] stk;
        logic [3:0] j0e, k0e, j1e, k1e;
        logic       oke;
        logic [3:0] mise;
        logic [7:0] erre;
        int         hold;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // Q before each row follows from the previous row (bank starts at 0000).
        tbl[0] = '{4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b1111, 1'b1, 4'b0000, 8'd0, 0};
        tbl[1] = '{4'b0101, 4'b0000, 4'b0101, 4'b1010, 4'b1111, 4'b1111, 1'b1, 4'b0000, 8'd0, 5};
        tbl[2] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0101, 4'b1111, 1'b0, 4'b0100, 8'd1, 0};
        tbl[3] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 8'd1, 0};
        tbl[4] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 8'd1, 0};
        tbl[5] = '{4'b0011, 4'b0000, 4'b0000, 4'b1100, 4'b1111, 4'b1100, 1'b1, 4'b0000, 8'd1, 0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_target = 4'b0000;
        rsp_ready  = 1'b0;
        stuck      = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", {30'd0, rr1, rr0}, 32'h3);
        chk("reset_jk", {16'd0, j0, k0, j1, k1}, 32'h0);
        chk("reset_rsp", {18'd0, rv1, rv0, ok1, ok0, mis1, mis0, 4'd0}, 32'h0);
        chk("reset_err", {16'd0, err1, err0}, 32'h0);

        // Stray rsp_ready in IDLE has no effect.
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_rsp_ready_ignored", {28'd0, rr1, rr0, rv1, rv0}, 32'hC);

        for (int i = 0; i < 6; i++) begin
            stuck = tbl[i].stk;
            run_txn(tbl[i].tgt, tbl[i].j0e, tbl[i].k0e, tbl[i].j1e, tbl[i].k1e,
                    tbl[i].oke, tbl[i].mise, tbl[i].erre, tbl[i].hold);
            stuck = 4'b0000;
        end

        // Reset during DRIVE aborts the transaction and clears the counter.
        req_valid  = 1'b1;
        req_target = 4'b1100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("pre_abort_j_dc0", {28'd0, j0}, 32'hC);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_jk", {16'd0, j0, k0, j1, k1}, 32'h0);
        chk("abort_rsp_valid", {30'd0, rv1, rv0}, 32'h0);
        chk("abort_err", {16'd0, err1, err0}, 32'h0);
        chk("abort_ready", {30'd0, rr1, rr0}, 32'h3);
        @(negedge clk);
        chk("abort_stays_idle", {28'd0, rr1, rr0, rv1, rv0}, 32'hC);

        // 256 failing requests: counter climbs to 8'hFF and sticks there.
        stuck = 4'b0100;
        for (int i = 0; i < 256; i++) begin
            run_txn(4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 1'b0, 4'b0100,
                    (i < 255) ? 8'(i + 1) : 8'hFF, 0);
        end
        stuck = 4'b0000;
        chk("err_saturated", {16'd0, err1, err0}, 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
